// File: rtl/reg_bank_responder.sv
// reg_bank_responder
//   Register bank that sits behind the serial command controller. Writes
//   land directly in the bank; a read request snapshots one register and
//   streams it to the serial transmitter one word at a time, most
//   significant word first, using a dv/done handshake per word.
//
// Ports
//   clk          clock, all logic on the rising edge
//   i_reset      synchronous active-high reset
//   i_w_addr     write address
//   i_w_data     write value (VALUE_WORDS*WORD_WIDTH bits)
//   i_w_en       write strobe, one write per high cycle
//   i_r_addr     read address
//   i_r_en       read strobe, rising edge starts a response
//   o_tx_data    word presented to the transmitter
//   o_tx_dv      one-cycle pulse: o_tx_data valid, start transmit
//   i_tx_done    one-cycle pulse from transmitter: word finished
//   o_busy       high while a response is in progress
//   o_overrun    sticky flag: a read arrived while busy and was dropped
//   o_regs       flat register contents, reg k at [(k+1)*V*W-1 : k*V*W]
//
// Build option
//   REG_BANK_ERR_RESP_EN  when defined, a read of an unimplemented address
//                         answers with a single 0xEE word instead of
//                         VALUE_WORDS zero words.
//
// state | meaning
// IDLE  | no response in progress, waiting for a read edge
// SEND  | present top word, pulse o_tx_dv
// WAIT  | hold the word until the transmitter reports done

module reg_bank_responder #(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int NUM_REGS    = 16
) (
  input  logic                                    clk,
  input  logic                                    i_reset,
  input  logic [WORD_WIDTH-1:0]                   i_w_addr,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0]       i_w_data,
  input  logic                                    i_w_en,
  input  logic [WORD_WIDTH-1:0]                   i_r_addr,
  input  logic                                    i_r_en,
  output logic [WORD_WIDTH-1:0]                   o_tx_data,
  output logic                                    o_tx_dv,
  input  logic                                    i_tx_done,
  output logic                                    o_busy,
  output logic                                    o_overrun,
  output logic [NUM_REGS*VALUE_WORDS*WORD_WIDTH-1:0] o_regs
);

  localparam int VAL_W = VALUE_WORDS * WORD_WIDTH;
  localparam int CNT_W = $clog2(VALUE_WORDS + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // One extra bit so NUM_REGS == 2**WORD_WIDTH is still representable.
  localparam logic [WORD_WIDTH:0] NUM_REGS_W = (WORD_WIDTH + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(VALUE_WORDS - 1);

`ifdef REG_BANK_ERR_RESP_EN
  localparam logic [WORD_WIDTH-1:0] ERR_WORD = WORD_WIDTH'('hEE);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [VAL_W-1:0] regs_q [NUM_REGS];
  logic [VAL_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             prev_r_en_q;
  logic             overrun_q;

  logic             rd_req;
  logic             load_snap;
  logic             advance;
  logic             w_in_range;
  logic             r_in_range;
  logic [VAL_W-1:0] snap_val;
  logic [CNT_W-1:0] snap_cnt;

  assign rd_req     = i_r_en & ~prev_r_en_q;
  assign w_in_range = ({1'b0, i_w_addr} < NUM_REGS_W);
  assign r_in_range = ({1'b0, i_r_addr} < NUM_REGS_W);

  // Register bank. Non-blocking update means a read snapshot taken on the
  // same edge as a write to the same address sees the old value.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (i_w_en && w_in_range) begin
      regs_q[i_w_addr[IDX_W-1:0]] <= i_w_data;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_regs[k*VAL_W +: VAL_W] = regs_q[k];
  end

  // Snapshot source. The error word is loaded into the top word with the
  // counter preset to the last word, so the normal WAIT exit sends just one.
  always_comb begin
    snap_val = '0;
    snap_cnt = '0;
    if (r_in_range) begin
      snap_val = regs_q[i_r_addr[IDX_W-1:0]];
    end else begin
`ifdef REG_BANK_ERR_RESP_EN
      snap_val[VAL_W-1 -: WORD_WIDTH] = ERR_WORD;
      snap_cnt                        = LAST_CNT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_tx_dv   = 1'b0;
    load_snap = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          load_snap = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        o_tx_dv = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          advance = 1'b1;
          state_d = (cnt_q == LAST_CNT) ? ST_IDLE : ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      prev_r_en_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prev_r_en_q <= i_r_en;
      if (rd_req && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (load_snap) begin
        shift_q <= snap_val;
        cnt_q   <= snap_cnt;
      end else if (advance) begin
        shift_q <= shift_q << WORD_WIDTH;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  // The word on the wire is always the top of the shift register; it only
  // moves on done, so it is stable for the whole SEND/WAIT of a word.
  assign o_tx_data = shift_q[VAL_W-1 -: WORD_WIDTH];
  assign o_busy    = (state_q != ST_IDLE);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_reg_bank_responder.sv
// Testbench for reg_bank_responder: directed scenarios followed by random
// writes and reads, all checked against an array/queue reference model.
// Honours REG_BANK_ERR_RESP_EN for the expected out-of-range response.

module tb_reg_bank_responder;

  localparam int WW    = 8;
  localparam int VW    = 4;
  localparam int NR    = 16;
  localparam int VAL_W = WW * VW;

  logic                  clk = 1'b0;
  logic                  i_reset = 1'b1;
  logic [WW-1:0]         i_w_addr = '0;
  logic [VAL_W-1:0]      i_w_data = '0;
  logic                  i_w_en = 1'b0;
  logic [WW-1:0]         i_r_addr = '0;
  logic                  i_r_en = 1'b0;
  logic                  i_tx_done = 1'b0;
  logic [WW-1:0]         o_tx_data;
  logic                  o_tx_dv;
  logic                  o_busy;
  logic                  o_overrun;
  logic [NR*VAL_W-1:0]   o_regs;

  always #5 clk = ~clk;

  reg_bank_responder #(
    .WORD_WIDTH (WW),
    .VALUE_WORDS(VW),
    .NUM_REGS   (NR)
  ) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_w_addr (i_w_addr),
    .i_w_data (i_w_data),
    .i_w_en   (i_w_en),
    .i_r_addr (i_r_addr),
    .i_r_en   (i_r_en),
    .o_tx_data(o_tx_data),
    .o_tx_dv  (o_tx_dv),
    .i_tx_done(i_tx_done),
    .o_busy   (o_busy),
    .o_overrun(o_overrun),
    .o_regs   (o_regs)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;

  always @(posedge clk) begin
    if (o_tx_dv === 1'b1) dv_count <= dv_count + 1;
  end

  logic [VAL_W-1:0] model_regs [NR];
  bit               model_ovr;
  logic [WW-1:0]    exp_q [$];

  int               stepno;
  int               r_hold;
  int               r_repulse;
  int               r_wr_step;
  logic [WW-1:0]    r_wr_addr;
  logic [VAL_W-1:0] r_wr_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s_reg%0d", tag, k), 64'(o_regs[k*VAL_W +: VAL_W]), 64'(model_regs[k]));
    end
  endtask

  task automatic wr(input logic [WW-1:0] a, input logic [VAL_W-1:0] d);
    i_w_addr = a;
    i_w_data = d;
    i_w_en   = 1'b1;
    @(negedge clk);
    i_w_en = 1'b0;
    if (int'(a) < NR) model_regs[a] = d;
  endtask

  // One cycle of a read transaction; applies the scheduled side stimulus.
  task automatic step();
    @(negedge clk);
    stepno++;
    i_tx_done = 1'b0;
    if (stepno == r_hold) i_r_en = 1'b0;
    if (r_repulse > 0 && stepno == r_repulse) i_r_en = 1'b1;
    if (r_repulse > 0 && stepno == r_repulse + 1) i_r_en = 1'b0;
    if (r_wr_step > 0 && stepno == r_wr_step) begin
      i_w_addr = r_wr_addr;
      i_w_data = r_wr_data;
      i_w_en   = 1'b1;
    end
    if (r_wr_step >= 0 && stepno == r_wr_step + 1) begin
      i_w_en = 1'b0;
      if (int'(r_wr_addr) < NR) model_regs[r_wr_addr] = r_wr_data;
    end
  endtask

  // Read a, answering each word with done 'delay' cycles after its dv.
  task automatic rd(input logic [WW-1:0] a, input int delay, input int hold,
                    input int repulse, input int wr_step,
                    input logic [WW-1:0] wa, input logic [VAL_W-1:0] wd);
    int dv0;
    exp_q.delete();
    if (int'(a) < NR) begin
      for (int w = 0; w < VW; w++) begin
        exp_q.push_back(WW'((model_regs[a] >> (WW * (VW - 1 - w))) & 32'hFF));
      end
    end else begin
`ifdef REG_BANK_ERR_RESP_EN
      exp_q.push_back(8'hEE);
`else
      for (int w = 0; w < VW; w++) exp_q.push_back(8'h00);
`endif
    end
    if (repulse > 0) model_ovr = 1'b1;
    dv0       = dv_count;
    stepno    = 0;
    r_hold    = hold;
    r_repulse = repulse;
    r_wr_step = wr_step;
    r_wr_addr = wa;
    r_wr_data = wd;
    i_r_addr  = a;
    i_r_en    = 1'b1;
    if (wr_step == 0) begin
      i_w_addr = wa;
      i_w_data = wd;
      i_w_en   = 1'b1;
    end
    for (int w = 0; w < exp_q.size(); w++) begin
      step();
      check($sformatf("rd%0h_w%0d_dv", a, w), 64'(o_tx_dv), 64'(1));
      check($sformatf("rd%0h_w%0d_data", a, w), 64'(o_tx_data), 64'(exp_q[w]));
      check($sformatf("rd%0h_w%0d_busy", a, w), 64'(o_busy), 64'(1));
      for (int d = 0; d < delay; d++) begin
        step();
        check($sformatf("rd%0h_w%0d_nodv", a, w), 64'(o_tx_dv), 64'(0));
        check($sformatf("rd%0h_w%0d_hold", a, w), 64'(o_tx_data), 64'(exp_q[w]));
      end
      i_tx_done = 1'b1;
    end
    step();
    check($sformatf("rd%0h_busy_end", a), 64'(o_busy), 64'(0));
    check($sformatf("rd%0h_dv_end", a), 64'(o_tx_dv), 64'(0));
    check($sformatf("rd%0h_dv_pulses", a), 64'(dv_count - dv0), 64'(exp_q.size()));
    check($sformatf("rd%0h_overrun", a), 64'(o_overrun), 64'(model_ovr));
    i_r_en    = 1'b0;
    r_wr_step = -1;
    r_repulse = -1;
    r_hold    = -1;
  endtask

  initial begin
    int dv0;
    int ws;
    for (int k = 0; k < NR; k++) model_regs[k] = '0;
    model_ovr = 1'b0;
    r_wr_step = -1;
    r_repulse = -1;
    r_hold    = -1;

    // Reset state
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_dv", 64'(o_tx_dv), 64'(0));
    check("rst_ovr", 64'(o_overrun), 64'(0));
    check("rst_data", 64'(o_tx_data), 64'(0));
    check_regs("rst");

    // Basic write and read with a slow transmitter
    wr(8'd3, 32'hDEADBEEF);
    check_regs("wr3");
    rd(8'd3, 5, 1, -1, -1, '0, '0);
    check("reg3_after", 64'(o_regs[3*VAL_W +: VAL_W]), 64'h00000000DEADBEEF);

    // Unwritten register, ignored out-of-range write, out-of-range read
    rd(8'd5, 2, 1, -1, -1, '0, '0);
    wr(8'd20, 32'h12345678);
    check_regs("wr20");
    rd(8'd20, 3, 1, -1, -1, '0, '0);

    // Snapshot isolation: write lands after the first word goes out
    wr(8'd3, 32'h11223344);
    rd(8'd3, 2, 1, -1, 2, 8'd3, 32'hAABBCCDD);
    check_regs("iso");
    rd(8'd3, 1, 1, -1, -1, '0, '0);

    // Second read edge while busy is dropped and sets the sticky flag
    rd(8'd3, 3, 1, 4, -1, '0, '0);
    dv0 = dv_count;
    repeat (8) @(negedge clk);
    check("ovr_no_extra", 64'(dv_count - dv0), 64'(0));
    check("ovr_sticky", 64'(o_overrun), 64'(1));

    // Read strobe held high for 10 cycles gives one response
    rd(8'd3, 2, 10, -1, -1, '0, '0);
    dv0 = dv_count;
    repeat (12) @(negedge clk);
    check("hold_no_extra", 64'(dv_count - dv0), 64'(0));

    // Same-cycle write and read of one address: read sees the old value
    wr(8'd2, 32'h9);
    rd(8'd2, 1, 1, -1, 0, 8'd2, 32'h5);
    check_regs("samecyc");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        wr(8'($urandom_range(0, NR + 7)), 32'($urandom));
        check_regs($sformatf("rnd%0d", i));
      end else begin
        ws = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : -1;
        rd(8'($urandom_range(0, NR + 7)), int'($urandom_range(1, 4)),
           int'($urandom_range(1, 2)), -1, ws,
           8'($urandom_range(0, NR + 3)), 32'($urandom));
      end
    end

    // Reset during the wait of the third word
    wr(8'd3, 32'hCAFEF00D);
    i_r_addr = 8'd3;
    i_r_en   = 1'b1;
    @(negedge clk);
    i_r_en = 1'b0;
    check("mid_w0", 64'(o_tx_data), 64'hCA);
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    check("mid_w1", 64'(o_tx_data), 64'hFE);
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    check("mid_w2_dv", 64'(o_tx_dv), 64'(1));
    check("mid_w2", 64'(o_tx_data), 64'hF0);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    for (int k = 0; k < NR; k++) model_regs[k] = '0;
    model_ovr = 1'b0;
    check("mid_rst_busy", 64'(o_busy), 64'(0));
    check("mid_rst_dv", 64'(o_tx_dv), 64'(0));
    check("mid_rst_ovr", 64'(o_overrun), 64'(0));
    check("mid_rst_data", 64'(o_tx_data), 64'(0));
    check_regs("mid_rst");
    dv0 = dv_count;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_dv", 64'(dv_count - dv0), 64'(0));
    check("mid_rst_idle", 64'(o_busy), 64'(0));
    rd(8'd3, 1, 1, -1, -1, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_responder.md
Name: reg_bank_responder

Overview:
- Register bank directly downstream of the serial command controller.
- Consumes its write strobe/address/data and read strobe/address.
- Stores NUM_REGS registers of VALUE_WORDS*WORD_WIDTH bits each.
- On a read, snapshots the addressed register and serializes it word-by-word, most significant word first, to the serial transmitter with a valid/done handshake.

Parameters:
- WORD_WIDTH, 8, bits per serial word and per address.
- VALUE_WORDS, 4, words per register value.
- NUM_REGS, 16, number of implemented registers (addresses 0..NUM_REGS-1); must be <= 2**WORD_WIDTH.

Ports:
- clk  input  1  clock; all logic on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_w_addr  input  WORD_WIDTH  write address.
- i_w_data  input  VALUE_WORDS*WORD_WIDTH  write value.
- i_w_en  input  1  write strobe; one write per high cycle.
- i_r_addr  input  WORD_WIDTH  read address.
- i_r_en  input  1  read strobe; rising edge starts a response.
- o_tx_data  output  WORD_WIDTH  word to transmitter; held stable while a word is outstanding.
- o_tx_dv  output  1  one-cycle pulse: o_tx_data valid, start transmit.
- i_tx_done  input  1  one-cycle pulse from transmitter: word finished.
- o_busy  output  1  high while a response is in progress.
- o_overrun  output  1  sticky; set when a read is requested while busy.
- o_regs  output  NUM_REGS*VALUE_WORDS*WORD_WIDTH  flat register contents; reg k occupies bits [(k+1)*V*W-1 : k*V*W].

Behaviour:
- Reset (i_reset high at posedge; wins over everything):
  - all registers, o_tx_data, o_tx_dv, o_busy and o_overrun go to 0; state goes to IDLE.
  - Reset mid-response aborts it; no further o_tx_dv.
- Writes:
  - Any state. i_w_en high with i_w_addr < NUM_REGS: register updated at that posedge.
  - i_w_addr >= NUM_REGS: ignored.
  - i_w_en held N cycles: N identical writes, harmless.
- Read edge detect:
  - rd_req = i_r_en & !prev_r_en, where prev_r_en is i_r_en registered.
  - A multi-cycle i_r_en pulse starts exactly one response.
- State machine, IDLE -> SEND -> WAIT -> (SEND | IDLE):
  - IDLE: on rd_req, load shift register with regs[i_r_addr] (0 if out of range), word count = 0, o_busy = 1 -> SEND.
  - Same-cycle i_w_en to the same address: the snapshot takes the OLD value.
  - SEND: o_tx_data = top word of shift register; o_tx_dv = 1 for exactly this cycle -> WAIT.
  - WAIT: hold o_tx_data. On i_tx_done: shift left by WORD_WIDTH, count + 1.
    - If count + 1 == VALUE_WORDS: -> IDLE, o_busy = 0.
    - Else -> SEND.
  - i_tx_done outside WAIT is ignored.
- Latency:
  - rd_req sampled at edge N -> o_tx_dv high in cycle N+1.
  - Next word's o_tx_dv: cycle after i_tx_done.
  - Back-to-back read accepted the cycle after o_busy falls.
- Snapshot isolation: writes during a response do not change words already captured.
- Overrun: rd_req while o_busy is dropped and sets o_overrun, which clears only on reset.
- Counter width: $clog2(VALUE_WORDS+1) bits; no wrap possible.

Optional Feature:
- Macro: REG_BANK_ERR_RESP_EN.
- Defined: a read of address >= NUM_REGS sends a single error word 0xEE (low WORD_WIDTH bits of 'hEE), then returns to IDLE (1 o_tx_dv pulse total).
- Undefined: the same read sends VALUE_WORDS words of 0.
- In-range reads are identical in both builds.

Test Plan:
- Reset, write addr 3 = 0xDEADBEEF, then read addr 3 with i_tx_done 5 cycles after each o_tx_dv -> o_tx_data sequence DE, AD, BE, EF; exactly 4 o_tx_dv pulses; o_busy falls the cycle after the 4th done; o_regs slice 3 = 0xDEADBEEF.
- Read addr 5 (never written) -> four 0x00 words. Write addr 20 (NUM_REGS = 16) -> o_regs unchanged. Read addr 20 -> four 0x00 words, or a single 0xEE with REG_BANK_ERR_RESP_EN.
- Start read of addr 3 (0x11223344), then write addr 3 = 0xAABBCCDD after the first word -> words 11, 22, 33, 44; a subsequent read returns AA, BB, CC, DD.
- Pulse i_r_en again while o_busy -> request dropped, o_overrun = 1 and stays 1. Hold i_r_en high 10 cycles in IDLE -> exactly one response.
- Same-cycle write addr 2 = 0x5 and read addr 2 (old value 0x9) -> response 00, 00, 00, 09.
- Assert i_reset during WAIT of word 2 -> next cycle o_busy = 0, o_tx_dv = 0, all o_regs = 0, o_overrun = 0; no further o_tx_dv pulses; a later i_tx_done is ignored.
